// File: rtl/dac_frame_sched_pkg.sv
// Shared constants and channel encoding for the DAC frame scheduler.
package dac_frame_sched_pkg;

  localparam int DAC_DW        = 8;
  localparam int DAC_FRAME_LEN = 16;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } ch_e;

endpackage

// File: rtl/dac_frame_sched_chan_buf.sv
// One-entry sample buffer per channel with repeat-last fallback and sticky underrun.
module dac_frame_sched_chan_buf #(
  parameter int DW = 8
) (
  input  logic          clk_4M,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          consume,
  output logic [DW-1:0] out_data,
  output logic          underrun
);

  logic          full;
  logic          accept;
  logic [DW-1:0] hold;
  logic [DW-1:0] last;

  // A consume frees the slot this same cycle, so a push can land without a bubble.
  assign push_ready = ~full | consume;
  assign accept     = push_valid & push_ready;
  assign out_data   = full ? hold : last;

  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      hold     <= '0;
      last     <= '0;
      underrun <= 1'b0;
    end else begin
      if (consume && full) begin
        last <= hold;
      end

      if (accept) begin
        hold <= push_data;
        full <= 1'b1;
      end else if (consume) begin
        full <= 1'b0;
      end

      // A fresh underrun outranks a clear in the same cycle.
      if (consume && !full) begin
        underrun <= 1'b1;
      end else if (clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dac_frame_sched.sv
// Frame strobe generator and A/B sample scheduler feeding the DACif serializer.
module dac_frame_sched
  import dac_frame_sched_pkg::*;
#(
  parameter int DW        = DAC_DW,
  parameter int FRAME_LEN = DAC_FRAME_LEN,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic          clk_4M,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clr_status,
  input  logic [DW-1:0] cha_data,
  input  logic          cha_valid,
  output logic          cha_ready,
  input  logic [DW-1:0] chb_data,
  input  logic          chb_valid,
  output logic          chb_ready,
  output logic [DW-1:0] din,
  output logic          a,
  output logic          dac_scen,
  output logic          frame_start,
  output logic          underrun_a,
  output logic          underrun_b
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             boundary;
  logic             consume_a;
  logic             consume_b;
  logic [DW-1:0]    a_out;
  logic [DW-1:0]    b_out;
  ch_e              ptr;

  assign boundary  = enable && (cnt == CNT_W'(FRAME_LEN - 1));
  assign cnt_next  = enable ? cnt + CNT_W'(1) : '0;
  assign consume_a = boundary && (ptr == CH_A);
  assign consume_b = boundary && (ptr == CH_B);

  dac_frame_sched_chan_buf #(.DW(DW)) u_buf_a (
    .clk_4M     (clk_4M),
    .rst_n      (rst_n),
    .clr        (clr_status),
    .push_valid (cha_valid),
    .push_data  (cha_data),
    .push_ready (cha_ready),
    .consume    (consume_a),
    .out_data   (a_out),
    .underrun   (underrun_a)
  );

  dac_frame_sched_chan_buf #(.DW(DW)) u_buf_b (
    .clk_4M     (clk_4M),
    .rst_n      (rst_n),
    .clr        (clr_status),
    .push_valid (chb_valid),
    .push_data  (chb_data),
    .push_ready (chb_ready),
    .consume    (consume_b),
    .out_data   (b_out),
    .underrun   (underrun_b)
  );

  // Strobe is high for the second half of each frame; din/a change only at the
  // wrap, a half frame before the rising edge where DACif samples them.
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dac_scen    <= 1'b0;
      frame_start <= 1'b0;
      ptr         <= CH_A;
      din         <= '0;
      a           <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      dac_scen    <= enable && (cnt_next >= CNT_W'(FRAME_LEN / 2));
      frame_start <= boundary;
      if (boundary) begin
        ptr <= (ptr == CH_A) ? CH_B : CH_A;
        din <= (ptr == CH_A) ? a_out : b_out;
        a   <= (ptr == CH_B);
      end
    end
  end

endmodule

// File: tb/tb_dac_frame_sched.sv
// Randomized scoreboard bench for dac_frame_sched against a queue-based frame model.
module tb_dac_frame_sched;

  logic       clk_4M = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       clr_status = 1'b0;
  logic [7:0] cha_data = 8'h00;
  logic       cha_valid = 1'b0;
  logic       cha_ready;
  logic [7:0] chb_data = 8'h00;
  logic       chb_valid = 1'b0;
  logic       chb_ready;
  logic [7:0] din;
  logic       a;
  logic       dac_scen;
  logic       frame_start;
  logic       underrun_a;
  logic       underrun_b;

  dac_frame_sched dut (
    .clk_4M      (clk_4M),
    .rst_n       (rst_n),
    .enable      (enable),
    .clr_status  (clr_status),
    .cha_data    (cha_data),
    .cha_valid   (cha_valid),
    .cha_ready   (cha_ready),
    .chb_data    (chb_data),
    .chb_valid   (chb_valid),
    .chb_ready   (chb_ready),
    .din         (din),
    .a           (a),
    .dac_scen    (dac_scen),
    .frame_start (frame_start),
    .underrun_a  (underrun_a),
    .underrun_b  (underrun_b)
  );

  initial forever #5 clk_4M = ~clk_4M;

  typedef struct packed {
    logic [7:0] din;
    logic       a;
    logic       ua;
    logic       ub;
  } exp_t;

  int         n_vec = 0;
  int         n_err = 0;
  exp_t       sb[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] last_a, last_b;
  bit         mptr;
  int         mcnt;
  bit         mur_a, mur_b;
  bit         exp_scen, exp_fs;
  logic [7:0] na, nb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete(); sb.delete();
    last_a = 8'h00; last_b = 8'h00;
    mptr = 1'b0; mcnt = 0; mur_a = 1'b0; mur_b = 1'b0;
    exp_scen = 1'b0; exp_fs = 1'b0;
  endtask

  // One clock: drive inputs after a falling edge, predict the next rising edge,
  // then check registered outputs at the following falling edge.
  task automatic step(input bit en, input bit va, input logic [7:0] da,
                      input bit vb, input logic [7:0] db, input bit clr,
                      output bit acc_a, output bit acc_b);
    bit bnd, rdy_a, rdy_b, nu_a, nu_b;
    logic [7:0] v;
    enable = en; cha_valid = va; cha_data = da;
    chb_valid = vb; chb_data = db; clr_status = clr;
    #1;
    bnd   = en && (mcnt == 15);
    rdy_a = (qa.size() == 0) || (bnd && !mptr);
    rdy_b = (qb.size() == 0) || (bnd && mptr);
    chk("cha_ready", cha_ready, rdy_a);
    chk("chb_ready", chb_ready, rdy_b);
    nu_a = 1'b0; nu_b = 1'b0; v = 8'h00;
    if (bnd) begin
      if (!mptr) begin
        if (qa.size() != 0) begin v = qa.pop_front(); last_a = v; end
        else begin v = last_a; nu_a = 1'b1; end
      end else begin
        if (qb.size() != 0) begin v = qb.pop_front(); last_b = v; end
        else begin v = last_b; nu_b = 1'b1; end
      end
    end
    mur_a = clr ? nu_a : (mur_a | nu_a);
    mur_b = clr ? nu_b : (mur_b | nu_b);
    acc_a = va && rdy_a;
    acc_b = vb && rdy_b;
    if (acc_a) qa.push_back(da);
    if (acc_b) qb.push_back(db);
    if (bnd) begin
      sb.push_back('{din: v, a: mptr, ua: mur_a, ub: mur_b});
      mptr = ~mptr;
    end
    mcnt     = en ? (mcnt + 1) % 16 : 0;
    exp_scen = en && (mcnt >= 8);
    exp_fs   = bnd;
    @(negedge clk_4M);
    chk("dac_scen", dac_scen, exp_scen);
    chk("frame_start", frame_start, exp_fs);
    chk("underrun_a", underrun_a, mur_a);
    chk("underrun_b", underrun_b, mur_b);
  endtask

  always @(negedge clk_4M) begin
    exp_t e;
    if (rst_n && frame_start) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL frame_unexpected: got frame_start 1 expected no frame at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("frame_din", din, e.din);
        chk("frame_a", a, e.a);
        chk("frame_ur_a", underrun_a, e.ua);
        chk("frame_ur_b", underrun_b, e.ub);
      end
    end
  end

  initial begin
    bit aa, ab;
    int off;
    int guard;
    model_reset();
    na = 8'h01; nb = 8'h81; off = 0;
    repeat (3) @(negedge clk_4M);
    chk("rst_din", din, 0);
    chk("rst_a", a, 0);
    chk("rst_scen", dac_scen, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_rdy_a", cha_ready, 1);
    chk("rst_rdy_b", chb_ready, 1);
    rst_n = 1'b1;

    // Both channels held valid with constant data: dummy, A, B, A ... and
    // every A push lands on the cycle that consumes the previous A.
    for (int i = 0; i < 80; i++) step(1, 1, 8'h11, 1, 8'h22, 0, aa, ab);

    // Randomized traffic, idle stretches and status clears.
    for (int i = 0; i < 1600; i++) begin
      bit en;
      if (off == 0 && $urandom_range(0, 120) == 0) off = $urandom_range(5, 25);
      en = (off == 0);
      if (off != 0) off--;
      step(en, $urandom_range(0, 3) != 0, na, $urandom_range(0, 4) > 1, nb,
           $urandom_range(0, 40) == 0, aa, ab);
      if (aa) na++;
      if (ab) nb++;
    end

    // Fill both buffers, then reset asynchronously at cnt=10.
    guard = 0;
    while (!(mcnt == 10 && qa.size() != 0 && qb.size() != 0) && guard < 200) begin
      step(1, 1, na, 1, nb, 0, aa, ab);
      if (aa) na++;
      if (ab) nb++;
      guard++;
    end
    chk("reset_setup_reached", guard < 200, 1);
    #2 rst_n = 1'b0;
    cha_valid = 1'b0; chb_valid = 1'b0; enable = 1'b0;
    #1;
    chk("async_din", din, 0);
    chk("async_a", a, 0);
    chk("async_scen", dac_scen, 0);
    chk("async_fs", frame_start, 0);
    chk("async_rdy_a", cha_ready, 1);
    chk("async_rdy_b", chb_ready, 1);
    chk("async_ur_a", underrun_a, 0);
    chk("async_ur_b", underrun_b, 0);
    model_reset();
    @(negedge clk_4M);
    @(negedge clk_4M);
    rst_n = 1'b1;

    // Single fresh A sample, B starved: expect B underrun repeating 0x00.
    step(1, 1, 8'h5A, 0, 8'h00, 0, aa, ab);
    for (int i = 0; i < 60; i++) step(1, 0, 8'h00, 0, 8'h00, 0, aa, ab);
    chk("starved_ur_b", underrun_b, 1);
    step(1, 0, 8'h00, 0, 8'h00, 1, aa, ab);
    chk("clr_ur_a", underrun_a, 0);
    chk("clr_ur_b", underrun_b, 0);

    for (int i = 0; i < 20; i++) step(0, 0, 8'h00, 0, 8'h00, 0, aa, ab);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
